instr_exec_regfile: RTL and testbench

//  Parametrised successor instruction register with an in-line execute unit.
//  - Accepts {opcode, operand_a, operand_b} over a valid/ready handshake.
//  - Computes the result: single-cycle ALU, or an iterative divider for DIV/MOD.
//  - Writes {opcode, a, b, result, status} into entry write_pointer of a DEPTH-entry array.
//  - The array is read asynchronously via read_pointer.

---
 rtl/instr_exec_regfile.sv | 220 ++++++++++++++++++++++
 tb/tb_instr_exec_regfile.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_regfile.sv
// Instruction register file with in-line execute unit: single-cycle ALU plus an
// iterative restoring divider. Define IRF_SATURATE_EN to clamp ADD/SUB/MULT results.
module instr_exec_regfile #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RES_W  = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [ADDR_W-1:0] write_pointer,
    input  logic [ADDR_W-1:0] read_pointer,
    output logic [2:0]        rd_opcode,
    output logic [DATA_W-1:0] rd_operand_a,
    output logic [DATA_W-1:0] rd_operand_b,
    output logic [RES_W-1:0]  rd_result,
    output logic [2:0]        rd_status,
    output logic              wr_done,
    output logic              x_drop
);

    localparam int                CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, DIV_RUN, WRITE} state_t;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [RES_W-1:0]  res;
        logic [2:0]        status;
    } entry_t;

    state_t state_reg, state_next;

    logic [2:0]        op_reg;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic [ADDR_W-1:0] wp_reg;
    logic [DATA_W-1:0] quo_reg, rem_reg, dvs_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              q_neg_reg, r_neg_reg;
    logic              wr_done_reg, x_drop_reg;

    logic              transfer, in_unknown, accept, is_div_in;
    logic [DATA_W-1:0] abs_a, abs_b;
    logic [DATA_W:0]   rem_shift, trial;
    logic              step_bit;
    logic [DATA_W-1:0] step_rem;

    logic [RES_W-1:0]  a_ext, b_ext, prod, exec_res, quo_ext, rem_ext, div_res;
    logic [DATA_W:0]   sum_w, dif_w;
    logic              exec_sat, exec_div0;

    logic              wr_en;
    entry_t            wr_ent;
    entry_t            ent [DEPTH];
    entry_t            rd_ent;

    assign in_ready   = (state_reg == IDLE);
    assign transfer   = in_valid && in_ready;
    assign in_unknown = $isunknown({opcode, operand_a, operand_b, write_pointer});
    assign accept     = transfer && !in_unknown;
    // A zero divisor takes the single-cycle path and is flagged there.
    assign is_div_in  = (opcode[2:1] == 2'b11) && (operand_b != '0);

    assign abs_a = operand_a[DATA_W-1] ? (~operand_a + 1'b1) : operand_a;
    assign abs_b = operand_b[DATA_W-1] ? (~operand_b + 1'b1) : operand_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = is_div_in ? DIV_RUN : EXEC;
            EXEC:    state_next = IDLE;
            DIV_RUN: if (cnt_reg == CNT_LAST) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Restoring step: the remainder never exceeds the divisor, so one spare bit is enough.
    assign rem_shift = {rem_reg, quo_reg[DATA_W-1]};
    assign trial     = rem_shift - {1'b0, dvs_reg};
    assign step_bit  = !trial[DATA_W];
    assign step_rem  = step_bit ? trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            wp_reg      <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            dvs_reg     <= '0;
            cnt_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            wr_done_reg <= 1'b0;
            x_drop_reg  <= 1'b0;
        end else begin
            wr_done_reg <= wr_en;
            x_drop_reg  <= transfer && in_unknown;
            if (accept) begin
                op_reg    <= opcode;
                a_reg     <= operand_a;
                b_reg     <= operand_b;
                wp_reg    <= write_pointer;
                quo_reg   <= abs_a;
                rem_reg   <= '0;
                dvs_reg   <= abs_b;
                cnt_reg   <= '0;
                q_neg_reg <= operand_a[DATA_W-1] ^ operand_b[DATA_W-1];
                r_neg_reg <= operand_a[DATA_W-1];
            end
            if (state_reg == DIV_RUN) begin
                rem_reg <= step_rem;
                quo_reg <= {quo_reg[DATA_W-2:0], step_bit};
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

`ifdef IRF_SATURATE_EN
    localparam logic [RES_W-1:0] SAT_MAX = {{(RES_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic [RES_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    always_comb begin
        a_ext     = {{(RES_W - DATA_W){a_reg[DATA_W-1]}}, a_reg};
        b_ext     = {{(RES_W - DATA_W){b_reg[DATA_W-1]}}, b_reg};
        sum_w     = {a_reg[DATA_W-1], a_reg} + {b_reg[DATA_W-1], b_reg};
        dif_w     = {a_reg[DATA_W-1], a_reg} - {b_reg[DATA_W-1], b_reg};
        prod      = a_ext * b_ext;
        exec_res  = '0;
        exec_sat  = 1'b0;
        exec_div0 = 1'b0;
        case (op_reg)
            3'd1:       exec_res = a_ext;
            3'd2:       exec_res = b_ext;
            3'd3:       exec_res = {{(RES_W - DATA_W - 1){sum_w[DATA_W]}}, sum_w};
            3'd4:       exec_res = {{(RES_W - DATA_W - 1){dif_w[DATA_W]}}, dif_w};
            3'd5:       exec_res = prod;
            3'd6, 3'd7: exec_div0 = 1'b1;
            default:    exec_res = '0;
        endcase
`ifdef IRF_SATURATE_EN
        if (op_reg inside {3'd3, 3'd4, 3'd5}) begin
            if ($signed(exec_res) > $signed(SAT_MAX)) begin
                exec_res = SAT_MAX;
                exec_sat = 1'b1;
            end else if ($signed(exec_res) < $signed(SAT_MIN)) begin
                exec_res = SAT_MIN;
                exec_sat = 1'b1;
            end
        end
`endif
    end

    // Magnitudes are zero-extended before negation so -2^(DW-1)/-1 stays exact.
    assign quo_ext = {{(RES_W - DATA_W){1'b0}}, quo_reg};
    assign rem_ext = {{(RES_W - DATA_W){1'b0}}, rem_reg};
    assign div_res = op_reg[0] ? (r_neg_reg ? -rem_ext : rem_ext)
                               : (q_neg_reg ? -quo_ext : quo_ext);

    assign wr_en = (state_reg == EXEC) || (state_reg == WRITE);

    always_comb begin
        wr_ent.op     = op_reg;
        wr_ent.a      = a_reg;
        wr_ent.b      = b_reg;
        wr_ent.res    = (state_reg == WRITE) ? div_res : exec_res;
        wr_ent.status = (state_reg == WRITE) ? 3'b001 : {exec_sat, exec_div0, 1'b1};
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            entry_t ent_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ent_reg <= '0;
                end else if (wr_en && (wp_reg == ADDR_W'(gi))) begin
                    ent_reg <= wr_ent;
                end
            end
            assign ent[gi] = ent_reg;
        end
    endgenerate

    always_comb begin
        rd_ent = '0;
        if ({1'b0, read_pointer} < DEPTH_LIM) begin
            rd_ent = ent[read_pointer];
        end
    end

    assign rd_opcode    = rd_ent.op;
    assign rd_operand_a = rd_ent.a;
    assign rd_operand_b = rd_ent.b;
    assign rd_result    = rd_ent.res;
    assign rd_status    = rd_ent.status;
    assign wr_done      = wr_done_reg;
    assign x_drop       = x_drop_reg;

endmodule

// File: tb/tb_instr_exec_regfile.sv
// Self-checking bench for instr_exec_regfile: directed scenarios plus randomized
// traffic against an arithmetic reference model (DEPTH=24 to reach out-of-range pointers).
module tb_instr_exec_regfile;

    localparam int DW    = 32;
    localparam int DEPTH = 24;
    localparam int AW    = 5;
    localparam int RW    = 64;

    typedef logic [3+DW+DW+RW+3-1:0] ent_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    opcode = '0;
    logic [DW-1:0] operand_a = '0;
    logic [DW-1:0] operand_b = '0;
    logic [AW-1:0] write_pointer = '0;
    logic [AW-1:0] read_pointer = '0;
    logic [2:0]    rd_opcode;
    logic [DW-1:0] rd_operand_a;
    logic [DW-1:0] rd_operand_b;
    logic [RW-1:0] rd_result;
    logic [2:0]    rd_status;
    logic          wr_done;
    logic          x_drop;

    int   n_cmp  = 0;
    int   n_fail = 0;
    ent_t model_mem [32];

    always #5 clk = ~clk;

    instr_exec_regfile #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RES_W(RW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
        .rd_result(rd_result), .rd_status(rd_status), .wr_done(wr_done), .x_drop(x_drop)
    );

    function automatic ent_t observed();
        return {rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_status};
    endfunction

    // Reference: plain 64-bit signed arithmetic; SV / and % truncate toward zero.
    function automatic ent_t reference(input logic [2:0] op, input int a, input int b);
        longint la = a;
        longint lb = b;
        longint r  = 0;
        bit     sat = 0;
        bit     d0  = 0;
        case (op)
            3'd1: r = la;
            3'd2: r = lb;
            3'd3: r = la + lb;
            3'd4: r = la - lb;
            3'd5: r = la * lb;
            3'd6: if (b == 0) d0 = 1; else r = la / lb;
            3'd7: if (b == 0) d0 = 1; else r = la % lb;
            default: r = 0;
        endcase
`ifdef IRF_SATURATE_EN
        if (op == 3'd3 || op == 3'd4 || op == 3'd5) begin
            if (r > 64'sd2147483647) begin r = 64'sd2147483647; sat = 1; end
            else if (r < -64'sd2147483648) begin r = -64'sd2147483648; sat = 1; end
        end
`endif
        return {op, a, b, r, sat, d0, 1'b1};
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input int b);
        return (op >= 3'd6 && b != 0) ? DW + 2 : 2;
    endfunction

    // Issues one request and counts edges (transfer edge = 1) until wr_done is seen.
    task automatic issue(input logic [2:0] op, input int a, input int b, input logic [AW-1:0] wp,
                         output int lat, output bit ready_leak);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        opcode = op; operand_a = a; operand_b = b; write_pointer = wp; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        ready_leak = 0;
        while (wr_done !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) ready_leak = 1;
            @(posedge clk); #1; lat++;
        end
        if (wp < DEPTH) model_mem[wp] = reference(op, a, b);
        $display("txn op=%0d a=%0d b=%0d wp=%0d lat=%0d", op, a, b, wp, lat);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++;
        if (wr_done !== 1'b0 || x_drop !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses got wr_done=%b x_drop=%b want 0 0", wr_done, x_drop);
        end
        for (int i = 0; i < 32; i++) begin
            read_pointer = AW'(i); #1;
            n_cmp++;
            if (observed() !== ent_t'(0)) begin
                n_fail++; $display("FAIL reset_entry[%0d] got=%h want=0", i, observed());
            end
        end
    endtask

    task automatic test_reset_mid_div();
        int lat; bit leak; int seen = 0;
        issue(3'd3, 11, 22, 5'd3, lat, leak);
        opcode = 3'd6; operand_a = 1000; operand_b = 7; write_pointer = 5'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL middiv_in_ready got=%b want=1", in_ready); end
        for (int i = 0; i < 32; i++) begin
            read_pointer = AW'(i); #1;
            n_cmp++;
            if (observed() !== ent_t'(0)) begin
                n_fail++; $display("FAIL middiv_entry[%0d] got=%h want=0", i, observed());
            end
        end
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (wr_done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_fail++; $display("FAIL middiv_no_wr_done got=%0d pulses want=0", seen); end
        $display("txn reset during DIV_RUN, wr_done pulses after=%0d", seen);
    endtask

    task automatic test_add();
        int lat; bit leak;
        issue(3'd3, 7, -3, 5'd5, lat, leak);
        read_pointer = 5'd5; #1;
        n_cmp++;
        if (lat != 2) begin n_fail++; $display("FAIL add_latency got=%0d want=2", lat); end
        n_cmp++;
        if (rd_result !== 64'd4) begin n_fail++; $display("FAIL add_result got=%0d want=4", $signed(rd_result)); end
        n_cmp++;
        if (rd_status !== 3'b001) begin n_fail++; $display("FAIL add_status got=%b want=001", rd_status); end
        n_cmp++;
        if (observed() !== model_mem[5]) begin
            n_fail++; $display("FAIL add_entry got=%h want=%h", observed(), model_mem[5]);
        end
    endtask

    task automatic test_div_mod();
        int lat; bit leak;
        issue(3'd6, -7, 2, 5'd1, lat, leak);
        read_pointer = 5'd1; #1;
        n_cmp++;
        if (lat != DW + 2 || leak) begin
            n_fail++; $display("FAIL div_latency got=%0d ready_leak=%0d want=%0d 0", lat, leak, DW + 2);
        end
        n_cmp++;
        if (rd_result !== -64'sd3) begin n_fail++; $display("FAIL div_result got=%0d want=-3", $signed(rd_result)); end
        issue(3'd7, -7, 2, 5'd2, lat, leak);
        read_pointer = 5'd2; #1;
        n_cmp++;
        if (lat != DW + 2 || leak) begin
            n_fail++; $display("FAIL mod_latency got=%0d ready_leak=%0d want=%0d 0", lat, leak, DW + 2);
        end
        n_cmp++;
        if (rd_result !== -64'sd1 || rd_status !== 3'b001) begin
            n_fail++; $display("FAIL mod_result got=%0d/%b want=-1/001", $signed(rd_result), rd_status);
        end
    endtask

    task automatic test_div0();
        int lat; bit leak;
        issue(3'd6, 9, 0, 5'd4, lat, leak);
        read_pointer = 5'd4; #1;
        n_cmp++;
        if (lat != 2) begin n_fail++; $display("FAIL div0_latency got=%0d want=2", lat); end
        n_cmp++;
        if (rd_result !== 64'd0 || rd_status !== 3'b011) begin
            n_fail++; $display("FAIL div0_result got=%0d/%b want=0/011", $signed(rd_result), rd_status);
        end
        issue(3'd7, -5, 0, 5'd4, lat, leak);
        n_cmp++;
        if (lat != 2 || observed() !== model_mem[4]) begin
            n_fail++; $display("FAIL mod0_entry got=%h lat=%0d want=%h lat=2", observed(), lat, model_mem[4]);
        end
    endtask

    task automatic test_mult_and_min();
        int lat; bit leak;
        issue(3'd5, 32'h7FFFFFFF, 2, 5'd6, lat, leak);
        read_pointer = 5'd6; #1;
        n_cmp++;
`ifdef IRF_SATURATE_EN
        if (rd_result !== 64'h00000000_7FFFFFFF || rd_status !== 3'b101) begin
            n_fail++; $display("FAIL mult_sat got=%h/%b want=000000007fffffff/101", rd_result, rd_status);
        end
`else
        if (rd_result !== 64'h00000000_FFFFFFFE || rd_status !== 3'b001) begin
            n_fail++; $display("FAIL mult_result got=%h/%b want=00000000fffffffe/001", rd_result, rd_status);
        end
`endif
        issue(3'd6, 32'h80000000, -1, 5'd7, lat, leak);
        read_pointer = 5'd7; #1;
        n_cmp++;
        if (rd_result !== 64'h00000000_80000000 || lat != DW + 2) begin
            n_fail++; $display("FAIL min_div got=%h lat=%0d want=0000000080000000 lat=%0d", rd_result, lat, DW + 2);
        end
    endtask

    task automatic test_x_drop();
        int lat; bit leak;
        logic probe;
        probe = 1'bx;
        // Only meaningful on a four-state simulator; elsewhere X collapses to a legal value.
        if ($isunknown(probe)) begin
            opcode = 3'd3; operand_a = 'x; operand_b = 1; write_pointer = 5'd8; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_cmp++;
            if (x_drop !== 1'b1 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL xdrop_pulse got x_drop=%b in_ready=%b want 1 1", x_drop, in_ready);
            end
            @(posedge clk); #1;
            read_pointer = 5'd8; #1;
            n_cmp++;
            if (x_drop !== 1'b0 || wr_done !== 1'b0 || observed() !== model_mem[8]) begin
                n_fail++; $display("FAIL xdrop_nowrite got x_drop=%b wr_done=%b entry=%h", x_drop, wr_done, observed());
            end
            $display("txn X operand dropped");
        end
        issue(3'd3, 100, 23, 5'd8, lat, leak);
        read_pointer = 5'd8; #1;
        n_cmp++;
        if (lat != 2 || observed() !== model_mem[8]) begin
            n_fail++; $display("FAIL xdrop_next_add got=%h lat=%0d want=%h lat=2", observed(), lat, model_mem[8]);
        end
    endtask

    task automatic test_pointers();
        int lat; bit leak;
        issue(3'd1, 55, 66, 5'd30, lat, leak);
        read_pointer = 5'd30; #1;
        n_cmp++;
        if (observed() !== ent_t'(0)) begin n_fail++; $display("FAIL oob_read30 got=%h want=0", observed()); end
        read_pointer = 5'd24; #1;
        n_cmp++;
        if (observed() !== ent_t'(0)) begin n_fail++; $display("FAIL oob_read24 got=%h want=0", observed()); end
        issue(3'd4, -9, 40, 5'd23, lat, leak);
        read_pointer = 5'd23; #1;
        n_cmp++;
        if (observed() !== model_mem[23]) begin
            n_fail++; $display("FAIL last_entry got=%h want=%h", observed(), model_mem[23]);
        end
        issue(3'd5, -12345, 678, 5'd9, lat, leak);
        issue(3'd2, 1, -77, 5'd9, lat, leak);
        read_pointer = 5'd9; #1;
        n_cmp++;
        if (observed() !== model_mem[9]) begin
            n_fail++; $display("FAIL overwrite got=%h want=%h", observed(), model_mem[9]);
        end
    endtask

    task automatic test_back_to_back();
        int   a [4];
        int   b [4];
        int   j = 0;
        for (int i = 0; i < 4; i++) begin a[i] = int'($urandom); b[i] = int'($urandom); end
        opcode = 3'd4; operand_a = a[0]; operand_b = b[0]; write_pointer = 5'd10; in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (in_ready !== (k % 2 == 0) || wr_done !== (k % 2 == 0)) begin
                n_fail++; $display("FAIL b2b_edge%0d got in_ready=%b wr_done=%b want %0d %0d",
                                   k, in_ready, wr_done, k % 2 == 0, k % 2 == 0);
            end
            if (k % 2 == 1) begin
                model_mem[10 + j] = reference(3'd4, a[j], b[j]);
                $display("txn b2b op=4 a=%0d b=%0d wp=%0d", a[j], b[j], 10 + j);
                j++;
                if (j < 4) begin operand_a = a[j]; operand_b = b[j]; write_pointer = AW'(10 + j); end
            end
        end
        in_valid = 1'b0;
        for (int i = 10; i < 14; i++) begin
            read_pointer = AW'(i); #1;
            n_cmp++;
            if (observed() !== model_mem[i]) begin
                n_fail++; $display("FAIL b2b_entry[%0d] got=%h want=%h", i, observed(), model_mem[i]);
            end
        end
    endtask

    task automatic test_random();
        int edge_vals [6] = '{32'h80000000, 32'h7FFFFFFF, -1, 0, 1, 2};
        for (int n = 0; n < 60; n++) begin
            logic [2:0]    op;
            logic [AW-1:0] wp;
            int a, b, lat;
            bit leak;
            op = 3'($urandom_range(0, 7));
            wp = AW'($urandom_range(0, 31));
            a  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : int'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : int'($urandom_range(0, 2000)) - 1000;
            issue(op, a, b, wp, lat, leak);
            n_cmp++;
            if (lat != exp_lat(op, b) || leak) begin
                n_fail++; $display("FAIL rand%0d_latency got=%0d leak=%0d want=%0d", n, lat, leak, exp_lat(op, b));
            end
            read_pointer = wp; #1;
            n_cmp++;
            if (observed() !== model_mem[wp]) begin
                n_fail++; $display("FAIL rand%0d_entry got=%h want=%h", n, observed(), model_mem[wp]);
            end
        end
        for (int i = 0; i < 32; i++) begin
            read_pointer = AW'(i); #1;
            n_cmp++;
            if (observed() !== model_mem[i]) begin
                n_fail++; $display("FAIL sweep[%0d] got=%h want=%h", i, observed(), model_mem[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        test_reset();
        test_reset_mid_div();
        test_add();
        test_div_mod();
        test_div0();
        test_mult_and_min();
        test_x_drop();
        test_pointers();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
